// File: rtl/ctrl_pkg.sv
// Shared opcodes, control-bundle encodings and field indices for ctrl_pipe_unit.
package ctrl_pkg;

    localparam int EX_W = 4;
    localparam int M_W  = 3;
    localparam int WB_W = 2;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_NOP   = 6'b100000;

    // EX = {RegDst, ALUOp[1:0], ALUSrc}
    localparam int REGDST_BIT = 3;
    localparam int ALUOP_HI   = 2;
    localparam int ALUOP_LO   = 1;
    localparam int ALUSRC_BIT = 0;
    // M = {Branch, MemRead, MemWrite}
    localparam int BRANCH_BIT   = 2;
    localparam int MEMREAD_BIT  = 1;
    localparam int MEMWRITE_BIT = 0;
    // WB = {RegWrite, MemtoReg}
    localparam int REGWRITE_BIT = 1;
    localparam int MEMTOREG_BIT = 0;

    localparam logic [EX_W-1:0] EX_RTYPE = 4'b1100;
    localparam logic [EX_W-1:0] EX_LW    = 4'b0001;
    localparam logic [EX_W-1:0] EX_SW    = 4'b0001;
    localparam logic [EX_W-1:0] EX_BEQ   = 4'b0010;
    localparam logic [EX_W-1:0] EX_ADDI  = 4'b0001;

    localparam logic [M_W-1:0] M_RTYPE = 3'b000;
    localparam logic [M_W-1:0] M_LW    = 3'b010;
    localparam logic [M_W-1:0] M_SW    = 3'b001;
    localparam logic [M_W-1:0] M_BEQ   = 3'b100;
    localparam logic [M_W-1:0] M_ADDI  = 3'b000;

    localparam logic [WB_W-1:0] WB_RTYPE = 2'b10;
    localparam logic [WB_W-1:0] WB_LW    = 2'b11;
    localparam logic [WB_W-1:0] WB_SW    = 2'b00;
    localparam logic [WB_W-1:0] WB_BEQ   = 2'b00;
    localparam logic [WB_W-1:0] WB_ADDI  = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control bundles, illegal flag and
// whether the instruction reads rt as a source.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic                valid,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [EX_W-1:0]     ex,
    output logic [M_W-1:0]      m,
    output logic [WB_W-1:0]     wb,
    output logic                illegal,
    output logic                uses_rt
);

    always_comb begin
        ex      = '0;
        m       = '0;
        wb      = '0;
        illegal = 1'b0;
        uses_rt = 1'b0;
        if (valid) begin
            case (opcode)
                OP_RTYPE: begin
                    ex      = EX_RTYPE;
                    m       = M_RTYPE;
                    wb      = WB_RTYPE;
                    uses_rt = 1'b1;
                end
                OP_LW: begin
                    ex = EX_LW;
                    m  = M_LW;
                    wb = WB_LW;
                end
                OP_SW: begin
                    ex      = EX_SW;
                    m       = M_SW;
                    wb      = WB_SW;
                    uses_rt = 1'b1;
                end
                OP_BEQ: begin
                    ex      = EX_BEQ;
                    m       = M_BEQ;
                    wb      = WB_BEQ;
                    uses_rt = 1'b1;
                end
                OP_ADDI: begin
                    ex = EX_ADDI;
                    m  = M_ADDI;
                    wb = WB_ADDI;
                end
                OP_NOP: ;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined MIPS control with load-use stall, branch flush, illegal counter.
// Define CTRL_PERF_EN to add saturating stall/flush performance counters.
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W  = 6,
    parameter int REG_W     = 5,
`ifdef CTRL_PERF_EN
    parameter int PERF_CNT_W = 16,
`endif
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [OPCODE_W-1:0]  id_opcode,
    input  logic [REG_W-1:0]     id_rs,
    input  logic [REG_W-1:0]     id_rt,
    input  logic                 flush,
    output logic                 stall,
    output logic [EX_W-1:0]      ex_ctrl,
    output logic [M_W-1:0]       mem_ctrl,
    output logic [WB_W-1:0]      wb_ctrl,
`ifdef CTRL_PERF_EN
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] flush_cnt,
`endif
    output logic [ILL_CNT_W-1:0] illegal_cnt
);

    logic [EX_W-1:0]  dec_ex;
    logic [M_W-1:0]   dec_m;
    logic [WB_W-1:0]  dec_wb;
    logic             dec_illegal;
    logic             dec_uses_rt;

    logic [EX_W-1:0]  idex_ex;
    logic [M_W-1:0]   idex_m;
    logic [WB_W-1:0]  idex_wb;
    logic [REG_W-1:0] ex_rt;
    logic [M_W-1:0]   exmem_m;
    logic [WB_W-1:0]  exmem_wb;
    logic [WB_W-1:0]  memwb_wb;

    logic             rs_hit;
    logic             rt_hit;

    ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .valid   (id_valid),
        .opcode  (id_opcode),
        .ex      (dec_ex),
        .m       (dec_m),
        .wb      (dec_wb),
        .illegal (dec_illegal),
        .uses_rt (dec_uses_rt)
    );

    // A bubble in ID/EX clears MemRead, so a hazard stalls only one cycle.
    assign rs_hit = (ex_rt == id_rs);
    assign rt_hit = dec_uses_rt & (ex_rt == id_rt);
    assign stall  = id_valid & idex_m[MEMREAD_BIT]
                  & (rs_hit | rt_hit) & ~flush;

    assign ex_ctrl  = idex_ex;
    assign mem_ctrl = exmem_m;
    assign wb_ctrl  = memwb_wb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_ex  <= '0;
            idex_m   <= '0;
            idex_wb  <= '0;
            ex_rt    <= '0;
            exmem_m  <= '0;
            exmem_wb <= '0;
            memwb_wb <= '0;
        end else begin
            memwb_wb <= exmem_wb;
            if (flush || stall) begin
                idex_ex <= '0;
                idex_m  <= '0;
                idex_wb <= '0;
                ex_rt   <= '0;
            end else begin
                idex_ex <= dec_ex;
                idex_m  <= dec_m;
                idex_wb <= dec_wb;
                ex_rt   <= id_rt;
            end
            if (flush) begin
                exmem_m  <= '0;
                exmem_wb <= '0;
            end else begin
                exmem_m  <= idex_m;
                exmem_wb <= idex_wb;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (dec_illegal && !stall && !flush && !(&illegal_cnt)) begin
            illegal_cnt <= illegal_cnt + ILL_CNT_W'(1);
        end
    end

`ifdef CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && !(&stall_cnt))
                stall_cnt <= stall_cnt + PERF_CNT_W'(1);
            if (flush && !(&flush_cnt))
                flush_cnt <= flush_cnt + PERF_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Randomized bench for ctrl_pipe_unit against an instruction-level model.
module tb_ctrl_pipe_unit;

    localparam int ILL_W  = 2;
    localparam int PERF_W = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [5:0] id_opcode;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       flush;
    logic       stall;
    logic [3:0] ex_ctrl;
    logic [2:0] mem_ctrl;
    logic [1:0] wb_ctrl;
    logic [ILL_W-1:0] illegal_cnt;
`ifdef CTRL_PERF_EN
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;
    bit cmp_en = 0;

    ctrl_pipe_unit #(.ILL_CNT_W(ILL_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_opcode   (id_opcode),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .flush       (flush),
        .stall       (stall),
        .ex_ctrl     (ex_ctrl),
        .mem_ctrl    (mem_ctrl),
        .wb_ctrl     (wb_ctrl),
`ifdef CTRL_PERF_EN
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
`endif
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    // Model: which instruction sits in each stage; controls come from a table.
    bit         m_idex_v;
    logic [5:0] m_idex_op;
    logic [4:0] m_idex_rt;
    bit         m_exmem_v;
    logic [5:0] m_exmem_op;
    bit         m_memwb_v;
    logic [5:0] m_memwb_op;
    int         m_ill;
    int         m_scnt;
    int         m_fcnt;

    function automatic logic [8:0] ctl(bit v, logic [5:0] op);
        if (!v) return 9'b0;
        case (op)
            6'b000000: return 9'b1100_000_10;
            6'b100011: return 9'b0001_010_11;
            6'b101011: return 9'b0001_001_00;
            6'b000100: return 9'b0010_100_00;
            6'b001000: return 9'b0001_000_10;
            default:   return 9'b0;
        endcase
    endfunction

    function automatic bit legal(logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011,
                          6'b000100, 6'b001000, 6'b100000};
    endfunction

    function automatic bit reads_rt(logic [5:0] op);
        return op inside {6'b000000, 6'b101011, 6'b000100};
    endfunction

    function automatic bit want_stall();
        return id_valid && m_idex_v && m_idex_op == 6'b100011
            && (m_idex_rt == id_rs
                || (reads_rt(id_opcode) && m_idex_rt == id_rt))
            && !flush;
    endfunction

    task automatic model_reset();
        m_idex_v  = 0; m_idex_op = '0; m_idex_rt = '0;
        m_exmem_v = 0; m_exmem_op = '0;
        m_memwb_v = 0; m_memwb_op = '0;
        m_ill = 0; m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic model_step();
        bit s;
        s = want_stall();
        if (id_valid && !legal(id_opcode) && !s && !flush
            && m_ill < (1 << ILL_W) - 1)
            m_ill++;
        if (s && m_scnt < (1 << PERF_W) - 1) m_scnt++;
        if (flush && m_fcnt < (1 << PERF_W) - 1) m_fcnt++;
        m_memwb_v  = m_exmem_v;
        m_memwb_op = m_exmem_op;
        if (flush) begin
            m_exmem_v = 0;
            m_idex_v  = 0;
        end else begin
            m_exmem_v  = m_idex_v;
            m_exmem_op = m_idex_op;
            m_idex_v   = !s && id_valid;
            m_idex_op  = id_opcode;
            m_idex_rt  = id_rt;
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    always @(negedge clk) begin
        logic [8:0] e_id;
        logic [8:0] e_mem;
        logic [8:0] e_wb;
        if (cmp_en) begin
            e_id  = ctl(m_idex_v, m_idex_op);
            e_mem = ctl(m_exmem_v, m_exmem_op);
            e_wb  = ctl(m_memwb_v, m_memwb_op);
            chk("stall", 32'(stall), 32'(want_stall() && rst_n));
            chk("ex_ctrl", 32'(ex_ctrl), 32'(e_id[8:5]));
            chk("mem_ctrl", 32'(mem_ctrl), 32'(e_mem[4:2]));
            chk("wb_ctrl", 32'(wb_ctrl), 32'(e_wb[1:0]));
            chk("illegal_cnt", 32'(illegal_cnt), 32'(m_ill));
`ifdef CTRL_PERF_EN
            chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
            chk("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
`endif
        end
    end

    task automatic drive(bit v, logic [5:0] op, logic [4:0] rs,
                         logic [4:0] rt, bit fl);
        id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    logic [5:0] ops [8];

    initial begin
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
        ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b100000;
        ops[6] = 6'b111111; ops[7] = 6'b010101;
        rst_n = 0;
        model_reset();
        drive(0, 6'b100000, 0, 0, 0);
        cmp_en = 1;
        tick();
        tick();
        chk("reset_ex", 32'(ex_ctrl), 0);
        chk("reset_stall", 32'(stall), 0);
        rst_n = 1;
        drive(1, 6'b100000, 0, 0, 0);
        tick();

        // RTYPE then ADDI back to back
        drive(1, 6'b000000, 1, 2, 0);
        tick();
        chk("rtype_ex", 32'(ex_ctrl), 32'h0C);
        drive(1, 6'b001000, 3, 4, 0);
        tick();
        chk("addi_ex", 32'(ex_ctrl), 32'h1);
        drive(1, 6'b100000, 0, 0, 0);
        tick();
        chk("rtype_wb", 32'(wb_ctrl), 32'h2);
        tick();
        chk("addi_wb", 32'(wb_ctrl), 32'h2);

        // Load-use: LW rt=5 then RTYPE rs=5
        drive(1, 6'b100011, 0, 5, 0);
        tick();
        drive(1, 6'b000000, 5, 1, 0);
        #1;
        chk("lu_stall", 32'(stall), 1);
        tick();
        chk("lu_bubble", 32'(ex_ctrl), 0);
        chk("lu_stall_off", 32'(stall), 0);
        tick();
        chk("lu_retry", 32'(ex_ctrl), 32'h0C);

        // LW rt=7 then ADDI rs=3 rt=7: rt not a source of ADDI
        drive(1, 6'b100011, 0, 7, 0);
        tick();
        drive(1, 6'b001000, 3, 7, 0);
        #1;
        chk("addi_nostall", 32'(stall), 0);
        tick();

        // Flush with a pending load-use condition
        drive(1, 6'b100011, 0, 4, 0);
        tick();
        drive(1, 6'b000000, 4, 0, 1);
        #1;
        chk("flush_stall", 32'(stall), 0);
        tick();
        chk("flush_ex", 32'(ex_ctrl), 0);
        chk("flush_mem", 32'(mem_ctrl), 0);
        drive(1, 6'b100000, 0, 0, 0);
        tick();

        // Illegal opcodes saturate the counter at 3
        drive(1, 6'b111111, 0, 0, 0);
        tick();
        chk("ill_1", 32'(illegal_cnt), 1);
        chk("ill_bubble", 32'(ex_ctrl), 0);
        drive(1, 6'b010101, 0, 0, 0);
        tick();
        chk("ill_2", 32'(illegal_cnt), 2);
        drive(1, 6'b000001, 0, 0, 0);
        tick();
        chk("ill_3", 32'(illegal_cnt), 3);
        drive(1, 6'b110000, 0, 0, 0);
        tick();
        chk("ill_sat", 32'(illegal_cnt), 3);

        // Mid-stream asynchronous reset with live registers
        drive(1, 6'b100011, 0, 1, 0);
        tick();
        drive(1, 6'b000000, 2, 3, 0);
        tick();
        rst_n = 0;
        model_reset();
        #1;
        chk("arst_ex", 32'(ex_ctrl), 0);
        chk("arst_mem", 32'(mem_ctrl), 0);
        chk("arst_wb", 32'(wb_ctrl), 0);
        chk("arst_cnt", 32'(illegal_cnt), 0);
        tick();
        rst_n = 1;
        drive(1, 6'b100000, 0, 0, 0);
        tick();
        tick();
        tick();
        chk("nop_ex", 32'(ex_ctrl), 0);
        chk("nop_wb", 32'(wb_ctrl), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) begin
                rst_n = 0;
                model_reset();
                tick();
                rst_n = 1;
            end
            drive($urandom_range(9) != 0,
                  ops[$urandom_range(7)],
                  5'($urandom_range(5)),
                  5'($urandom_range(5)),
                  $urandom_range(9) == 0);
            tick();
        end

        @(negedge clk);
        cmp_en = 0;
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
Second-generation MIPS control unit: decodes the ID-stage opcode into EX/M/WB control bundles and carries them through the ID/EX, EX/MEM and MEM/WB control registers. Adds ADDI decode, load-use hazard detection with stall/bubble insertion, branch flush, and a saturating illegal-opcode counter. Sits beside the datapath pipeline registers and feeds ALU, memory and register-file controls directly.

Parameters:
OPCODE_W, 6, opcode width
REG_W, 5, register specifier width
ILL_CNT_W, 8, illegal-opcode counter width
PERF_CNT_W, 16, performance counter width (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a real instruction
id_opcode  in  OPCODE_W  ID-stage opcode
id_rs  in  REG_W  ID-stage rs
id_rt  in  REG_W  ID-stage rt
flush  in  1  branch taken, resolved in MEM
stall  out  1  hold PC and IF/ID; combinational
ex_ctrl  out  4  {RegDst, ALUOp[1:0], ALUSrc}, ID/EX register
mem_ctrl  out  3  {Branch, MemRead, MemWrite}, EX/MEM register
wb_ctrl  out  2  {RegWrite, MemtoReg}, MEM/WB register
illegal_cnt  out  ILL_CNT_W  count of illegal opcodes decoded

Behaviour:
- Reset (rst_n low, asynchronous): all control registers, ex_rt, and illegal_cnt go to 0; stall is 0 while in reset.
- Decode, combinational. Don't-care fields are driven 0, never z.
  - RTYPE 000000: EX 1100, M 000, WB 10.
  - LW 100011: EX 0001, M 010, WB 11.
  - SW 101011: EX 0001, M 001, WB 00.
  - BEQ 000100: EX 0010, M 100, WB 00.
  - ADDI 001000: EX 0001, M 000, WB 10.
  - NOP 100000: all 0.
  - Any other opcode with id_valid=1 is illegal: decodes to all 0 (bubble).
  - id_valid=0 decodes to a bubble.
- Pipeline: the ID/EX register holds {EX, M, WB, rt}; EX/MEM holds {M, WB}; MEM/WB holds {WB}.
  - ex_ctrl is valid 1 cycle after decode, mem_ctrl 2 cycles after, wb_ctrl 3 cycles after.
  - All three registers advance every cycle; there is no global enable.
- Load-use hazard:
  - stall = id_valid & ID/EX.MemRead & (ex_rt==id_rs | ex_rt==id_rt) & ~flush.
  - The rs comparison applies to every opcode; rt is compared for RTYPE, SW and BEQ only.
  - While stall=1, ID/EX loads a bubble (all 0) and EX/MEM, MEM/WB advance normally.
  - stall lasts exactly one cycle per hazard, because the bubble clears MemRead.
- Flush:
  - flush=1 loads bubbles into ID/EX and EX/MEM at the next edge.
  - MEM/WB advances normally from EX/MEM (the branch's own WB, which is 00).
- Simultaneous flush and stall: flush wins; stall is forced 0.
- illegal_cnt: increments on every edge where an illegal opcode is decoded, stall=0 and flush=0. It saturates at all-ones; there is no wrap.
- Mid-operation reset clears everything immediately; no partial state survives.

Optional Feature:
CTRL_PERF_EN
- Defined: adds outputs stall_cnt and flush_cnt, PERF_CNT_W bits each, reset to 0.
  - stall_cnt counts cycles with stall=1.
  - flush_cnt counts cycles with flush=1.
  - Both saturate at all-ones.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams (RTYPE, LW, SW, BEQ, ADDI, NOP);
  - bundle widths EX_W=4, M_W=3, WB_W=2;
  - per-opcode EX/M/WB encodings;
  - field bit indices (MEMREAD_BIT etc.).
- Sub-module ctrl_decode: purely combinational opcode -> {EX, M, WB, illegal}. The top level owns the registers, the hazard logic and the counters.

Test Plan:
- Reset: hold rst_n=0 mid-stream with nonzero registers -> every output is 0 immediately (asynchronous); after release, NOP outputs stay 0.
- RTYPE then ADDI, back-to-back, no hazard -> ex_ctrl=1100 at T+1 and 0001 at T+2; wb_ctrl=10 at T+3 and T+4.
- LW rt=5, then RTYPE rs=5 -> stall=1 for exactly one cycle, ex_ctrl=0000 bubble that cycle, then ex_ctrl=1100 on the retry.
- LW rt=7, then ADDI rs=3 rt=7 -> no stall (rt not compared for ADDI).
- BEQ reaching MEM with flush=1 while a load-use stall condition is present -> stall=0; the next cycle has ex_ctrl=0000 and mem_ctrl=000.
- Illegal opcodes: 3 illegal opcodes with ILL_CNT_W=2 -> illegal_cnt counts 1, 2, 3; a fourth keeps it at 3; illegal opcodes produce bubbles.
